mul8_iter: RTL and testbench
============================

Name: mul8_iter

Overview:
- Iterative 8x8 unsigned shift-add multiplier for the EX-stage multiply path.
- Sits directly downstream of the team's 8-bit carry-select adder `csa8`: it instantiates one `csa8` and consumes its sum and carry-out each iteration to build a 16-bit product.
- Start/busy/done handshake toward the pipeline control.

Parameters:
- EARLY_EXIT, 0: when 1, terminate as soon as the remaining multiplier bits are all zero; when 0, always run 8 iterations.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- mcand  in  8  multiplicand, captured when start is accepted
- mplier  in  8  multiplier, captured when start is accepted
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; product valid
- product  out  16  result; held stable until the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0x0000, internal accumulators and counter cleared.
- Reset mid-operation: the in-flight multiply is abandoned. Next cycle is IDLE with the same reset values, and no done pulse is issued.
- Registers:
  - acc_hi[7:0]
  - acc_lo[7:0], loaded with mplier
  - mq[7:0], copy of mplier for early-exit detection
  - mc[7:0], latched mcand
  - cnt[3:0]
- State IDLE:
  - busy=0, done=0.
  - start=1 loads acc_hi=0, acc_lo=mplier, mq=mplier, mc=mcand, cnt=0, then goes to RUN.
- State RUN (busy=1), one iteration per cycle:
  - The `csa8` instance computes acc_hi + (acc_lo[0] ? mc : 0) with carry_in=0.
  - Next value: {acc_hi,acc_lo} = {cout, sum, acc_lo[7:1]}, a 17-to-16 right shift that keeps the adder carry as the new MSB.
  - mq >>= 1; cnt++.
  - When cnt reaches 8 after the update, go to DONE.
  - The `csa8` overflow output is unused; the product is unsigned.
- EARLY_EXIT=1:
  - If mq==0 at the start of a RUN cycle, that cycle skips the add.
  - It loads {acc_hi,acc_lo} >>= (8-cnt) in one step and goes to DONE.
  - mplier=0 therefore finishes after one RUN cycle.
- State DONE:
  - done=1, busy=0, product={acc_hi,acc_lo} registered on entry; lasts exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE: done pulses, and the next cycle is RUN with the new operands.
  - Otherwise the block returns to IDLE.
- Latency with EARLY_EXIT=0: start sampled high in cycle N, busy high in cycles N+1..N+8, done high in N+9. Throughput is 9 cycles per multiply with back-to-back starts.
- start while in RUN is ignored; the operands are not recaptured.
- product changes only on entry to DONE or on reset.
- Output order: busy and done are never high together, and both are registered outputs.

Decomposition:
- Shared package mul_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - MUL_W=8, PROD_W=16, CNT_W=4
- One sub-module: the existing `csa8` adder, instantiated once for the per-iteration add. There is no other hierarchy; the control FSM and datapath registers live in mul8_iter.

Test Plan:
- Basic multiply (EARLY_EXIT=0): mcand=200, mplier=150, start one cycle -> busy for 8 cycles, done in cycle N+9, product=0x7530 (30000).
- Max operands: mcand=255, mplier=255 -> product=0xFE01. Checks that the adder carry-out is captured into the acc_hi MSB on every iteration.
- Early exit (EARLY_EXIT=1):
  - mcand=128, mplier=1 -> done after 2 RUN cycles, product=0x0080.
  - mplier=0 -> 1 RUN cycle, product=0x0000.
  - Same operands with EARLY_EXIT=0 -> 8 RUN cycles, identical products.
- Handshake:
  - start re-asserted with new operands during RUN -> ignored; product is from the first operands (e.g. 13*11=0x008F).
  - start held high through DONE -> a second multiply starts immediately, 9-cycle spacing between done pulses.
- Reset mid-run: rst high at iteration 4 of 200*150 -> next cycle busy=0, done=0, product=0x0000, no done pulse. A subsequent 3*5 -> product=0x000F.
- Random: 1000 random operand pairs on both EARLY_EXIT settings -> product equals mcand*mplier, and done latency equals the formula for that setting.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding and datapath widths.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/csa8.sv
// 8-bit carry-select adder: ripple low nibble, high nibble precomputed for both carries.
module csa8
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             cin,
  output logic [MUL_W-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    // Low-nibble carry picks which precomputed high half to use.
    if (lo[4]) begin
      sum  = {hi1[3:0], lo[3:0]};
      cout = hi1[4];
    end else begin
      sum  = {hi0[3:0], lo[3:0]};
      cout = hi0[4];
    end
    ovf = (a[7] == b[7]) && (sum[7] != a[7]);
  end

endmodule

// File: rtl/mul8_iter.sv
// Iterative 8x8 unsigned shift-add multiplier with start/busy/done handshake.
// One csa8 add per RUN cycle; optional early exit once the multiplier bits run out.
module mul8_iter
  import mul_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MUL_W-1:0]  mcand,
  input  logic [MUL_W-1:0]  mplier,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_e            state_q;
  logic [MUL_W-1:0]  acc_hi_q;
  logic [MUL_W-1:0]  acc_lo_q;
  logic [MUL_W-1:0]  mq_q;
  logic [MUL_W-1:0]  mc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [PROD_W-1:0] product_q;

  logic [MUL_W-1:0]  add_b;
  logic [MUL_W-1:0]  add_sum;
  logic              add_cout;
  logic              add_ovf_unused;
  logic              skip;
  logic              last;
  logic [CNT_W-1:0]  shamt;
  logic [PROD_W-1:0] acc_d;

  csa8 u_add (
    .a    (acc_hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf_unused)
  );

  always_comb begin
    add_b = acc_lo_q[0] ? mc_q : '0;
    skip  = EARLY_EXIT && (mq_q == '0);
    shamt = CNT_W'(MUL_W) - cnt_q;
    // Adder carry becomes the new MSB; early exit collapses the remaining shifts.
    if (skip) begin
      acc_d = {acc_hi_q, acc_lo_q} >> shamt;
    end else begin
      acc_d = {add_cout, add_sum, acc_lo_q[MUL_W-1:1]};
    end
    last = skip || (cnt_q == CNT_W'(MUL_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mq_q      <= '0;
      mc_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_hi_q <= '0;
            acc_lo_q <= mplier;
            mq_q     <= mplier;
            mc_q     <= mcand;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          {acc_hi_q, acc_lo_q} <= acc_d;
          mq_q  <= mq_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= acc_d;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul8_iter.sv
// Directed and random checks of mul8_iter with both EARLY_EXIT settings side by side.
module tb_mul8_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy0, done0, busy1, done1;
  logic [15:0] product0, product1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul8_iter #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy0), .done(done0), .product(product0)
  );

  mul8_iter #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy1), .done(done1), .product(product1)
  );

  // RUN-cycle count expected with early exit enabled.
  function automatic int ee_runs(input logic [7:0] m);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (m[i]) p = i + 1;
    if (p == 0) return 1;
    if (p == 8) return 8;
    return p + 1;
  endfunction

  // Issue one start pulse and observe both instances until each has pulsed done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat0, output int lat1,
                        output int bsy0, output int bsy1,
                        output logic [15:0] p0, output logic [15:0] p1,
                        output logic ovl);
    lat0 = 0; lat1 = 0; bsy0 = 0; bsy1 = 0; p0 = 16'hxxxx; p1 = 16'hxxxx; ovl = 1'b0;
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy0) bsy0++;
      if (busy1) bsy1++;
      if (done0 && lat0 == 0) begin lat0 = k; p0 = product0; end
      if (done1 && lat1 == 0) begin lat1 = k; p1 = product1; end
      if ((busy0 && done0) || (busy1 && done1)) ovl = 1'b1;
      if (lat0 != 0 && lat1 != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy0, done0, busy1, done1});
    end
    checks++;
    if (product0 !== 16'h0000 || product1 !== 16'h0000) begin
      errors++; $display("FAIL reset_product: got %h/%h expected 0000", product0, product1);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int l0, l1, b0, b1; logic [15:0] p0, p1; logic ov;
    run_op(8'd200, 8'd150, l0, l1, b0, b1, p0, p1, ov);
    checks++;
    if (p0 !== 16'h7530) begin errors++; $display("FAIL basic_prod: got %h expected 7530", p0); end
    checks++;
    if (l0 !== 9 || b0 !== 8) begin errors++; $display("FAIL basic_timing: done at %0d busy %0d expected 9/8", l0, b0); end
    checks++;
    if (p1 !== 16'h7530 || l1 !== 9) begin errors++; $display("FAIL basic_ee: got %h at %0d expected 7530 at 9", p1, l1); end
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL basic_overlap: busy and done high together"); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy0); end
  endtask

  task automatic test_max;
    int l0, l1, b0, b1; logic [15:0] p0, p1; logic ov;
    run_op(8'd255, 8'd255, l0, l1, b0, b1, p0, p1, ov);
    checks++;
    if (p0 !== 16'hFE01 || p1 !== 16'hFE01) begin
      errors++; $display("FAIL max_prod: got %h/%h expected FE01", p0, p1);
    end
  endtask

  task automatic test_early_exit;
    int l0, l1, b0, b1; logic [15:0] p0, p1; logic ov;
    run_op(8'd128, 8'd1, l0, l1, b0, b1, p0, p1, ov);
    checks++;
    if (p1 !== 16'h0080 || b1 !== 2 || l1 !== 3) begin
      errors++; $display("FAIL ee_128x1: got %h runs %0d done %0d expected 0080 runs 2 done 3", p1, b1, l1);
    end
    checks++;
    if (p0 !== 16'h0080 || b0 !== 8) begin
      errors++; $display("FAIL noee_128x1: got %h runs %0d expected 0080 runs 8", p0, b0);
    end
    run_op(8'd77, 8'd0, l0, l1, b0, b1, p0, p1, ov);
    checks++;
    if (p1 !== 16'h0000 || b1 !== 1 || l1 !== 2) begin
      errors++; $display("FAIL ee_zero: got %h runs %0d done %0d expected 0000 runs 1 done 2", p1, b1, l1);
    end
    checks++;
    if (p0 !== 16'h0000 || b0 !== 8) begin
      errors++; $display("FAIL noee_zero: got %h runs %0d expected 0000 runs 8", p0, b0);
    end
  endtask

  task automatic test_ignore_start;
    logic [15:0] p0, p1; int l0, l1;
    l0 = 0; l1 = 0; p0 = 16'hxxxx; p1 = 16'hxxxx;
    @(negedge clk);
    start = 1'b1; mcand = 8'd13; mplier = 8'd11;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin start = 1'b1; mcand = 8'd99; mplier = 8'd99; end
      if (k == 4) start = 1'b0;
      if (done0 && l0 == 0) begin l0 = k; p0 = product0; end
      if (done1 && l1 == 0) begin l1 = k; p1 = product1; end
      if (l0 != 0 && l1 != 0) break;
      @(negedge clk);
    end
    checks++;
    if (p0 !== 16'h008F || l0 !== 9) begin
      errors++; $display("FAIL ignore_start: got %h at %0d expected 008F at 9", p0, l0);
    end
    checks++;
    if (p1 !== 16'h008F || l1 !== 6) begin
      errors++; $display("FAIL ignore_start_ee: got %h at %0d expected 008F at 6", p1, l1);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int first, second; logic [15:0] pf, ps, held;
    first = 0; second = 0; pf = 16'hxxxx; ps = 16'hxxxx; held = 16'hxxxx;
    @(negedge clk);
    start = 1'b1; mcand = 8'd200; mplier = 8'd150;
    @(negedge clk);
    mcand = 8'd3; mplier = 8'd5;
    for (int k = 1; k <= 30; k++) begin
      if (done0) begin
        if (first == 0) begin first = k; pf = product0; end
        else if (second == 0) begin second = k; ps = product0; end
      end
      if (k == 10) held = product0;
      if (second != 0) break;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (first !== 9 || pf !== 16'h7530) begin
      errors++; $display("FAIL b2b_first: got %h at %0d expected 7530 at 9", pf, first);
    end
    checks++;
    if (second - first !== 9 || ps !== 16'h000F) begin
      errors++; $display("FAIL b2b_second: got %h spacing %0d expected 000F spacing 9", ps, second - first);
    end
    checks++;
    if (held !== 16'h7530) begin
      errors++; $display("FAIL b2b_held: got %h expected 7530", held);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int l0, l1, b0, b1, pulses; logic [15:0] p0, p1; logic ov;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; mcand = 8'd200; mplier = 8'd150;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      errors++; $display("FAIL midrst_ctrl: got %b expected 0000", {busy0, done0, busy1, done1});
    end
    checks++;
    if (product0 !== 16'h0000 || product1 !== 16'h0000) begin
      errors++; $display("FAIL midrst_product: got %h/%h expected 0000", product0, product1);
    end
    for (int k = 0; k < 12; k++) begin
      if (done0 || done1 || busy0 || busy1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", pulses); end
    run_op(8'd3, 8'd5, l0, l1, b0, b1, p0, p1, ov);
    checks++;
    if (p0 !== 16'h000F || l0 !== 9 || p1 !== 16'h000F) begin
      errors++; $display("FAIL midrst_after: got %h/%h at %0d expected 000F at 9", p0, p1, l0);
    end
  endtask

  task automatic test_random;
    int l0, l1, b0, b1; logic [15:0] p0, p1, exp; logic ov; logic [7:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp = 16'(a) * 16'(b);
      run_op(a, b, l0, l1, b0, b1, p0, p1, ov);
      checks++;
      if (p0 !== exp || l0 !== 9) begin
        errors++; $display("FAIL rand_noee %0d*%0d: got %h at %0d expected %h at 9", a, b, p0, l0, exp);
      end
      checks++;
      if (p1 !== exp || l1 !== ee_runs(b) + 1) begin
        errors++; $display("FAIL rand_ee %0d*%0d: got %h at %0d expected %h at %0d", a, b, p1, l1, exp, ee_runs(b) + 1);
      end
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL rand_overlap %0d*%0d: busy and done together", a, b); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_early_exit();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
